// File: rtl/core_oprandstage.sv
// core_oprandstage -- operand stage between ID and EX of the i2d core.
// Forwards EX/MEM writeback data into the A/B operands, inserts bubbles on
// unresolvable RAW hazards, registers the operands behind a valid/ready
// handshake and keeps a saturating count of hazard stall cycles.
//
// Build option: define I2D_OPMUX_FWD_EN to enable the EX/MEM forwarding
// paths (only an EX-stage load then stalls). Without it, operands always
// come from the register file and any pending EX/MEM write to a used
// source register stalls the instruction.
module core_oprandstage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    // ID side
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [DW-1:0] ra,
    input  logic [DW-1:0] rb,
    input  logic [RW-1:0] ra_idx,
    input  logic [RW-1:0] rb_idx,
    input  logic          ra_use,
    input  logic          rb_use,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] imm,
    input  logic [1:0]    sel_a,
    input  logic [1:0]    sel_b,
    // pending writebacks
    input  logic          ex_wr_en,
    input  logic [RW-1:0] ex_wr_idx,
    input  logic [DW-1:0] ex_wr_data,
    input  logic          ex_is_load,
    input  logic          mem_wr_en,
    input  logic [RW-1:0] mem_wr_idx,
    input  logic [DW-1:0] mem_wr_data,
    // pipeline control
    input  logic          flush,
    input  logic          ex_ready,
    // EX side
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic          ex_valid,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        SEL_A_RA    = 2'd0,
        SEL_A_PC    = 2'd1,
        SEL_A_ZERO2 = 2'd2,
        SEL_A_ZERO3 = 2'd3
    } sel_a_e;

    typedef enum logic [1:0] {
        SEL_B_RB   = 2'd0,
        SEL_B_PC   = 2'd1,
        SEL_B_IMM  = 2'd2,
        SEL_B_ZERO = 2'd3
    } sel_b_e;

    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic          ex_valid_q, ex_valid_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    logic [DW-1:0] fwd_a, fwd_b;
    logic [DW-1:0] op_a, op_b;
    logic          ex_match_a, ex_match_b;
    logic          mem_match_a, mem_match_b;
    logic          hazard;
    logic          advance;

    assign ex_match_a  = ex_wr_en  & (ex_wr_idx  == ra_idx);
    assign ex_match_b  = ex_wr_en  & (ex_wr_idx  == rb_idx);
    assign mem_match_a = mem_wr_en & (mem_wr_idx == ra_idx);
    assign mem_match_b = mem_wr_en & (mem_wr_idx == rb_idx);

`ifdef I2D_OPMUX_FWD_EN
    // Forwarding: EX (youngest writer) beats MEM; a load in EX has no data yet.
    always_comb begin
        fwd_a = ra;
        fwd_b = rb;
        if (ex_match_a & ~ex_is_load) fwd_a = ex_wr_data;
        else if (mem_match_a)         fwd_a = mem_wr_data;
        if (ex_match_b & ~ex_is_load) fwd_b = ex_wr_data;
        else if (mem_match_b)         fwd_b = mem_wr_data;
    end

    // Only a load in EX feeding a used source cannot be forwarded.
    assign hazard = ex_is_load & ((ra_use & ex_match_a) | (rb_use & ex_match_b));
`else
    // Without forwarding the register file read data is used directly.
    assign fwd_a = ra;
    assign fwd_b = rb;

    // Any pending write to a used source must drain before issue.
    assign hazard = (ra_use & (ex_match_a | mem_match_a)) |
                    (rb_use & (ex_match_b | mem_match_b));

    // Writeback data and load flag are only consumed by the forwarding build.
    logic unused_nofwd;
    assign unused_nofwd = ^{ex_is_load, ex_wr_data, mem_wr_data};
`endif

    // Operand selection applied on top of the forwarded register values.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        op_a = '0;
        op_b = '0;
        unique case (sel_a_e'(sel_a))
            SEL_A_RA:    op_a = fwd_a;
            SEL_A_PC:    op_a = id_pc;
            SEL_A_ZERO2: op_a = '0;
            SEL_A_ZERO3: op_a = '0;
        endcase
        unique case (sel_b_e'(sel_b))
            SEL_B_RB:   op_b = fwd_b;
            SEL_B_PC:   op_b = id_pc;
            SEL_B_IMM:  op_b = imm;
            SEL_B_ZERO: op_b = '0;
        endcase
    end

    assign advance  = ~ex_valid_q | ex_ready;
    assign id_ready = advance & ~hazard & ~flush;

    // Next-state for the operand register, valid flag and stall counter.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        ex_valid_d  = ex_valid_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (advance) begin
            if (id_valid & ~hazard) begin
                a_d        = op_a;
                b_d        = op_b;
                ex_valid_d = 1'b1;
            end else begin
                ex_valid_d = 1'b0;
            end
        end

        if (id_valid & hazard & ~flush & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign ex_valid  = ex_valid_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_core_oprandstage.sv
// Self-checking bench for core_oprandstage: table of directed vectors plus
// hand-written load-use, back-pressure, flush, saturation and reset sequences.
// Expectations follow the I2D_OPMUX_FWD_EN setting of the build.
module tb_core_oprandstage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

`ifdef I2D_OPMUX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic          id_ready;
    logic [DW-1:0] ra, rb, id_pc, imm;
    logic [RW-1:0] ra_idx, rb_idx;
    logic          ra_use, rb_use;
    logic [1:0]    sel_a, sel_b;
    logic          ex_wr_en, ex_is_load, mem_wr_en;
    logic [RW-1:0] ex_wr_idx, mem_wr_idx;
    logic [DW-1:0] ex_wr_data, mem_wr_data;
    logic          flush, ex_ready;
    logic [DW-1:0] a, b;
    logic          ex_valid;
    logic [CW-1:0] stall_cnt;

    core_oprandstage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .ra(ra), .rb(rb), .ra_idx(ra_idx), .rb_idx(rb_idx),
        .ra_use(ra_use), .rb_use(rb_use),
        .id_pc(id_pc), .imm(imm), .sel_a(sel_a), .sel_b(sel_b),
        .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx), .ex_wr_data(ex_wr_data),
        .ex_is_load(ex_is_load),
        .mem_wr_en(mem_wr_en), .mem_wr_idx(mem_wr_idx), .mem_wr_data(mem_wr_data),
        .flush(flush), .ex_ready(ex_ready),
        .a(a), .b(b), .ex_valid(ex_valid), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          id_valid;
        logic [1:0]    sel_a, sel_b;
        logic [DW-1:0] ra, rb, id_pc, imm;
        logic [RW-1:0] ra_idx, rb_idx;
        logic          ra_use, rb_use;
        logic          ex_wr_en, ex_is_load;
        logic [RW-1:0] ex_wr_idx;
        logic [DW-1:0] ex_wr_data;
        logic          mem_wr_en;
        logic [RW-1:0] mem_wr_idx;
        logic [DW-1:0] mem_wr_data;
        logic          flush, ex_ready;
        logic          exp_ready;
        logic [DW-1:0] exp_a, exp_b;
        logic          exp_valid;
        logic          exp_inc;
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_stall = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t base();
        vec_t v;
        v.id_valid = 1'b1;  v.sel_a = 2'd0;  v.sel_b = 2'd2;
        v.ra = 32'h11;  v.rb = 32'h33;  v.id_pc = 32'h100;  v.imm = 32'h22;
        v.ra_idx = 5'd1;  v.rb_idx = 5'd2;  v.ra_use = 1'b1;  v.rb_use = 1'b1;
        v.ex_wr_en = 1'b0;  v.ex_is_load = 1'b0;  v.ex_wr_idx = '0;  v.ex_wr_data = '0;
        v.mem_wr_en = 1'b0;  v.mem_wr_idx = '0;  v.mem_wr_data = '0;
        v.flush = 1'b0;  v.ex_ready = 1'b1;
        v.exp_ready = 1'b1;  v.exp_a = 32'h11;  v.exp_b = 32'h22;
        v.exp_valid = 1'b1;  v.exp_inc = 1'b0;
        return v;
    endfunction

    // Drive one cycle at the falling edge, check id_ready, then the registered outputs.
    task automatic apply(input vec_t v, input string tag);
        id_valid = v.id_valid;  sel_a = v.sel_a;  sel_b = v.sel_b;
        ra = v.ra;  rb = v.rb;  id_pc = v.id_pc;  imm = v.imm;
        ra_idx = v.ra_idx;  rb_idx = v.rb_idx;  ra_use = v.ra_use;  rb_use = v.rb_use;
        ex_wr_en = v.ex_wr_en;  ex_is_load = v.ex_is_load;
        ex_wr_idx = v.ex_wr_idx;  ex_wr_data = v.ex_wr_data;
        mem_wr_en = v.mem_wr_en;  mem_wr_idx = v.mem_wr_idx;  mem_wr_data = v.mem_wr_data;
        flush = v.flush;  ex_ready = v.ex_ready;
        #1;
        check({tag, ".id_ready"}, 32'(id_ready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        if (v.exp_inc && exp_stall != {CW{1'b1}}) exp_stall = exp_stall + 1'b1;
        check({tag, ".a"}, a, v.exp_a);
        check({tag, ".b"}, b, v.exp_b);
        check({tag, ".ex_valid"}, 32'(ex_valid), 32'(v.exp_valid));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        @(negedge clk);
    endtask

    vec_t tbl[$];
    vec_t v;
    vec_t ld;

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        v = base();
        v.id_valid = 1'b0;
        id_valid = 0; sel_a = 0; sel_b = 0; ra = 0; rb = 0; id_pc = 0; imm = 0;
        ra_idx = 0; rb_idx = 0; ra_use = 0; rb_use = 0;
        ex_wr_en = 0; ex_is_load = 0; ex_wr_idx = 0; ex_wr_data = 0;
        mem_wr_en = 0; mem_wr_idx = 0; mem_wr_data = 0; flush = 0; ex_ready = 0;
        #1;
        check("reset.a", a, 32'h0);
        check("reset.b", b, 32'h0);
        check("reset.ex_valid", 32'(ex_valid), 32'h0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- vector table ----------------
        v = base();                                                   // v0 RA / IMM
        tbl.push_back(v);
        v = base(); v.sel_a = 2'd3; v.sel_b = 2'd3;                   // v1 zeros
        v.exp_a = 32'h0; v.exp_b = 32'h0; tbl.push_back(v);
        v = base(); v.sel_a = 2'd1; v.sel_b = 2'd0;                   // v2 PC / RB
        v.exp_a = 32'h100; v.exp_b = 32'h33; tbl.push_back(v);
        v = base(); v.sel_a = 2'd2; v.sel_b = 2'd1;                   // v3 zero / PC
        v.exp_a = 32'h0; v.exp_b = 32'h100; tbl.push_back(v);
        v = base(); v.id_valid = 1'b0; v.sel_a = 2'd1; v.sel_b = 2'd0;// v4 idle bubble
        v.exp_a = 32'h0; v.exp_b = 32'h100; v.exp_valid = 1'b0; tbl.push_back(v);
        v = base(); v.ra_idx = 5'd3;                                  // v5 EX and MEM hit
        v.ex_wr_en = 1'b1; v.ex_wr_idx = 5'd3; v.ex_wr_data = 32'hAAAA;
        v.mem_wr_en = 1'b1; v.mem_wr_idx = 5'd3; v.mem_wr_data = 32'hBBBB;
        v.exp_ready = FWD; v.exp_valid = FWD; v.exp_inc = !FWD;
        v.exp_a = FWD ? 32'hAAAA : 32'h0; v.exp_b = FWD ? 32'h22 : 32'h100;
        tbl.push_back(v);
        v.ex_wr_en = 1'b0;                                            // v6 MEM hit only
        v.exp_a = FWD ? 32'hBBBB : 32'h0; tbl.push_back(v);
        v = base(); v.ra_idx = 5'd3; v.ra_use = 1'b0;                 // v7 unused source
        v.ex_wr_en = 1'b1; v.ex_wr_idx = 5'd3; v.ex_wr_data = 32'hAAAA;
        v.mem_wr_en = 1'b1; v.mem_wr_idx = 5'd3; v.mem_wr_data = 32'hBBBB;
        v.exp_a = FWD ? 32'hAAAA : 32'h11; tbl.push_back(v);
        v.ex_is_load = 1'b1;                                          // v8 load skips EX
        v.exp_a = FWD ? 32'hBBBB : 32'h11; tbl.push_back(v);
        v = base(); v.flush = 1'b1; v.sel_a = 2'd1;                   // v9 flush
        v.exp_ready = 1'b0; v.exp_valid = 1'b0;
        v.exp_a = FWD ? 32'hBBBB : 32'h11; tbl.push_back(v);
        v = base(); v.rb_idx = 5'd7; v.sel_b = 2'd0;                  // v10 load-use on rb
        v.ex_wr_en = 1'b1; v.ex_is_load = 1'b1; v.ex_wr_idx = 5'd7;
        v.exp_ready = 1'b0; v.exp_valid = 1'b0; v.exp_inc = 1'b1;
        v.exp_a = FWD ? 32'hBBBB : 32'h11; tbl.push_back(v);
        v = base(); tbl.push_back(v);                                 // v11 recover

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // ---------------- load-use: one bubble then MEM forward ----------------
        ld = base(); ld.ra_use = 1'b0; ld.rb_idx = 5'd5; ld.sel_b = 2'd0; ld.rb = 32'hDEAD;
        ld.ex_wr_en = 1'b1; ld.ex_is_load = 1'b1; ld.ex_wr_idx = 5'd5; ld.ex_wr_data = 32'hFFFF;
        ld.exp_ready = 1'b0; ld.exp_valid = 1'b0; ld.exp_inc = 1'b1;
        ld.exp_a = 32'h11; ld.exp_b = 32'h22;
        apply(ld, "lu.bubble");
        v = ld; v.ex_wr_en = 1'b0; v.ex_is_load = 1'b0;
        v.mem_wr_en = 1'b1; v.mem_wr_idx = 5'd5; v.mem_wr_data = 32'h1234;
        v.exp_ready = FWD; v.exp_valid = FWD; v.exp_inc = !FWD;
        v.exp_b = FWD ? 32'h1234 : 32'h22;
        apply(v, "lu.mem_fwd");
        v.mem_wr_en = 1'b0; v.exp_ready = 1'b1; v.exp_valid = 1'b1; v.exp_inc = 1'b0;
        v.exp_b = 32'hDEAD;
        apply(v, "lu.drained");

        // ---------------- back-pressure: EX not ready for 3 cycles ----------------
        v = base(); v.ra = 32'h55; v.imm = 32'h66; v.exp_a = 32'h55; v.exp_b = 32'h66;
        apply(v, "bp.load");
        for (int i = 0; i < 3; i++) begin
            v = base(); v.ex_ready = 1'b0; v.sel_a = 2'(i);
            v.ra = 32'h1000 + i; v.imm = 32'h2000 + i; v.id_pc = 32'h3000 + i;
            v.exp_ready = 1'b0; v.exp_a = 32'h55; v.exp_b = 32'h66;
            apply(v, $sformatf("bp.hold%0d", i));
        end

        // ---------------- flush during hazard: no stall counted ----------------
        v = ld; v.flush = 1'b1; v.exp_inc = 1'b0; v.exp_a = 32'h55; v.exp_b = 32'h66;
        apply(v, "flush_hz");

        // ---------------- saturation: 2^CW+3 hazard cycles ----------------
        v = ld; v.exp_a = 32'h55; v.exp_b = 32'h66;
        for (int i = 0; i < (1 << CW) + 3; i++) apply(v, $sformatf("sat%0d", i));
        check("sat.all_ones", 32'(stall_cnt), 32'(4'hF));

        // ---------------- asynchronous reset mid-stall ----------------
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        exp_stall = '0;
        check("areset.a", a, 32'h0);
        check("areset.b", b, 32'h0);
        check("areset.ex_valid", 32'(ex_valid), 32'h0);
        check("areset.stall_cnt", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        v = base();
        apply(v, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
